// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite signal bundle shared by the manager stage and the SRAM subordinate.
interface ahb_sram_subordinate_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  logic                      hsel;
  logic [AddressWidth-1:0]   haddr;
  logic [1:0]                htrans;
  logic                      hwrite;
  logic [2:0]                hsize;
  logic [2:0]                hburst;
  logic [DataWidth-1:0]      hwdata;
  logic [DataWidth/8-1:0]    hwstrb;
  logic                      hready;
  logic                      hreadyout;
  logic                      hresp;
  logic [DataWidth-1:0]      hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-organised SRAM: address decode,
// configurable wait states, byte-strobed writes, forwarded registered reads
// and the two-cycle ERROR response for illegal transfers.
module ahb_sram_subordinate #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32,
  parameter int MemoryDepth  = 1024,
  parameter int WaitStates   = 0
) (
  input logic                    hclk,
  input logic                    hreset,
  ahb_sram_subordinate_if.slave  bus
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int ByteShift = $clog2(StrbWidth);
  localparam int IdxWidth  = (MemoryDepth > 1) ? $clog2(MemoryDepth) : 1;
  localparam logic [3:0] WaitInit = 4'((WaitStates > 0) ? (WaitStates - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   pend_write_q, pend_write_d;
  logic [IdxWidth-1:0]    addr_q, addr_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [DataWidth-1:0]   hrdata_q, hrdata_d;
  logic [DataWidth-1:0]   mem_q [MemoryDepth];

  logic [AddressWidth-1:0] word_idx_s;
  logic [AddressWidth-1:0] align_mask_s;
  logic                    legal_s;
  logic                    accept_s;
  logic                    complete_s;
  logic                    commit_s;
  logic                    rd_load_s;
  logic                    err_load_s;
  logic [IdxWidth-1:0]     rd_idx_s;
  logic [DataWidth-1:0]    wr_word_s;
  logic [DataWidth-1:0]    rd_word_s;
  logic                    unused_ok_s;

  // Byte-lane merge of new write data into an existing word.
  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [StrbWidth-1:0] strb
  );
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < StrbWidth; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign unused_ok_s = ^{bus.hburst, bus.htrans[0]};

  // Address-phase decode, legality check and data-phase bookkeeping strobes.
  always_comb begin
    word_idx_s   = bus.haddr >> ByteShift;
    align_mask_s = AddressWidth'((32'd1 << bus.hsize) - 32'd1);
    legal_s      = ((32'd8 << bus.hsize) <= 32'(DataWidth)) &&
                   ((bus.haddr & align_mask_s) == '0) &&
                   (32'(word_idx_s) < 32'(MemoryDepth));
    // hreadyout_q is high only in IDLE/ERR2, the states able to take a new address.
    accept_s     = bus.hsel && bus.htrans[1] && bus.hready && hreadyout_q;
    complete_s   = (state_q == ST_IDLE) && pend_q;
    commit_s     = complete_s && pend_write_q && !hreset;
    err_load_s   = accept_s && !legal_s;
    // Reads load hrdata on the edge that enters their completing cycle.
    rd_load_s    = (accept_s && legal_s && !bus.hwrite && (WaitStates == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd0) && !pend_write_q);
    if (state_q == ST_WAIT) begin
      rd_idx_s = addr_q;
    end else begin
      rd_idx_s = word_idx_s[IdxWidth-1:0];
    end
  end

  // Array read with forwarding of a write committing on the same edge.
  always_comb begin
    wr_word_s = merge_bytes(mem_q[addr_q], bus.hwdata, bus.hwstrb);
    if (commit_s && (rd_idx_s == addr_q)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
  end

  // Next-state logic of the transfer FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_write_d = pend_write_q;
    addr_d       = addr_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (complete_s) begin
          pend_d = 1'b0;
        end else begin
          pend_d = pend_q;
        end
        if (accept_s) begin
          if (legal_s) begin
            pend_d       = 1'b1;
            pend_write_d = bus.hwrite;
            addr_d       = word_idx_s[IdxWidth-1:0];
            if (WaitStates > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WaitInit;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d      = ST_ERR1;
            pend_d       = 1'b0;
            pend_write_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_load_s) begin
      hrdata_d = rd_word_s;
    end else if (err_load_s) begin
      hrdata_d = '0;
    end else begin
      hrdata_d = hrdata_q;
    end

    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      addr_q       <= '0;
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
      hrdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_write_q <= pend_write_d;
      addr_q       <= addr_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
    end
  end

  // SRAM array write port; contents survive reset.
  always_ff @(posedge hclk) begin
    if (commit_s) begin
      mem_q[addr_q] <= wr_word_s;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Scoreboard bench for ahb_sram_subordinate: three instances with 0, 3 and 5
// wait states share one stimulus driver, selected through hsel.
module tb_ahb_sram_subordinate;
  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  typedef struct {
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
    logic        stall_resp;
  } obs_t;

  logic        hclk;
  logic        hreset;
  int          sel;
  bit          hsel_r;
  logic [19:0] haddr_r;
  logic [1:0]  htrans_r;
  logic        hwrite_r;
  logic [2:0]  hsize_r;
  logic [31:0] hwdata_r;
  logic [3:0]  hwstrb_r;

  logic        ro_a [3];
  logic        rs_a [3];
  logic [31:0] rd_a [3];
  logic        ro_m;
  logic        rs_m;
  logic [31:0] rd_m;

  txn_t        txq [$];
  exp_t        expq [$];
  obs_t        obsq [$];
  logic [31:0] model [int];

  int          n_cmp;
  int          n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_subordinate_if #(.AddressWidth(20), .DataWidth(32)) bus ();
    assign bus.hsel   = hsel_r && (sel == g);
    assign bus.haddr  = haddr_r;
    assign bus.htrans = htrans_r;
    assign bus.hwrite = hwrite_r;
    assign bus.hsize  = hsize_r;
    assign bus.hburst = 3'd0;
    assign bus.hwdata = hwdata_r;
    assign bus.hwstrb = hwstrb_r;
    assign bus.hready = bus.hreadyout;
    assign ro_a[g]    = bus.hreadyout;
    assign rs_a[g]    = bus.hresp;
    assign rd_a[g]    = bus.hrdata;
    ahb_sram_subordinate #(
      .AddressWidth(20),
      .DataWidth(32),
      .MemoryDepth(1024),
      .WaitStates((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .hclk(hclk),
      .hreset(hreset),
      .bus(bus)
    );
  end

  assign ro_m = ro_a[sel];
  assign rs_m = rs_a[sel];
  assign rd_m = rd_a[sel];

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int cur_ws();
    return (sel == 0) ? 0 : ((sel == 1) ? 3 : 5);
  endfunction

  // Queue a transfer and push its expected outcome from the reference model.
  task automatic add_txn(input bit wr, input logic [19:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [3:0] strb);
    txn_t t;
    exp_t e;
    int   bytes;
    int   key;
    bit   legal;
    logic [31:0] w;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.strb = strb;
    txq.push_back(t);
    bytes = 1 << size;
    legal = ((8 << size) <= 32) && ((int'(addr) % bytes) == 0) && ((int'(addr) >> 2) < 1024);
    key = sel * 2048 + (int'(addr) >> 2);
    e.err = !legal;
    e.waits = legal ? cur_ws() : 1;
    e.chk_data = !legal || !wr;
    e.rdata = 32'd0;
    if (legal && wr) begin
      w = model.exists(key) ? model[key] : 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
      end
      model[key] = w;
    end else if (legal) begin
      e.rdata = model.exists(key) ? model[key] : 32'hXXXXXXXX;
    end
    expq.push_back(e);
  endtask

  // Pipelined AHB driver: issues queued transfers and records each data phase.
  task automatic run_seq();
    int   issued;
    int   waits;
    int   guard;
    bit   dp_valid;
    bit   acc;
    logic last_resp;
    txn_t cur;
    obs_t o;
    issued = 0; waits = 0; guard = 0; dp_valid = 1'b0; last_resp = 1'b0;
    cur = '{wr: 1'b0, addr: 20'd0, size: 3'd0, wdata: 32'd0, strb: 4'd0};
    while (((issued < txq.size()) || dp_valid) && (guard < 300)) begin
      if (issued < txq.size()) begin
        hsel_r = 1'b1; htrans_r = 2'd2; hwrite_r = txq[issued].wr;
        haddr_r = txq[issued].addr; hsize_r = txq[issued].size;
      end else begin
        hsel_r = 1'b0; htrans_r = 2'd0;
      end
      if (dp_valid) begin
        hwdata_r = cur.wdata; hwstrb_r = cur.strb;
      end
      @(negedge hclk);
      acc = (issued < txq.size()) && (ro_m === 1'b1);
      if (dp_valid) begin
        if (ro_m !== 1'b1) begin
          waits++;
          last_resp = rs_m;
        end else begin
          o.resp = rs_m; o.rdata = rd_m; o.waits = waits; o.stall_resp = last_resp;
          obsq.push_back(o);
          dp_valid = 1'b0;
        end
      end
      @(posedge hclk); #1;
      if (acc) begin
        cur = txq[issued]; issued++; dp_valid = 1'b1; waits = 0; last_resp = 1'b0;
      end
      guard++;
    end
    hsel_r = 1'b0; htrans_r = 2'd0;
    n_cmp++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL run_seq_timeout: got %0d cycles, want < 300", guard);
    end
    txq.delete();
  endtask

  task automatic test_reset();
    hreset = 1'b1; sel = 0; hsel_r = 1'b0; htrans_r = 2'd0; hwrite_r = 1'b0;
    haddr_r = 20'd0; hsize_r = 3'd2; hwdata_r = 32'd0; hwstrb_r = 4'd0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ((ro_a[i] !== 1'b1) || (rs_a[i] !== 1'b0) || (rd_a[i] !== 32'd0)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got ready=%b resp=%b rdata=%h, want 1 0 00000000",
                 i, ro_a[i], rs_a[i], rd_a[i]);
      end
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_write_read();
    exp_t e;
    obs_t o;
    sel = 0;
    add_txn(1'b1, 20'h00010, 3'd2, 32'hDEADBEEF, 4'hF);
    add_txn(1'b0, 20'h00010, 3'd2, 32'd0, 4'h0);
    run_seq();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (obsq.size() == 0) begin
        n_fail++; $display("FAIL write_read missing: got no response, want one");
      end else begin
        o = obsq.pop_front();
        if ((o.resp !== e.err) || (o.waits != e.waits) || (o.stall_resp !== e.err)) begin
          n_fail++;
          $display("FAIL write_read resp: got resp=%b waits=%0d, want resp=%b waits=%0d",
                   o.resp, o.waits, e.err, e.waits);
        end
        if (e.chk_data) begin
          n_cmp++;
          if (o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL write_read data: got %h, want %h", o.rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    sel = 0;
    add_txn(1'b1, 20'h00020, 3'd2, 32'hAABBCCDD, 4'hF);
    add_txn(1'b1, 20'h00020, 3'd2, 32'h00000011, 4'h1);
    add_txn(1'b0, 20'h00020, 3'd2, 32'd0, 4'h0);
    add_txn(1'b1, 20'h00024, 3'd2, 32'h55667788, 4'hC);
    add_txn(1'b0, 20'h00024, 3'd2, 32'd0, 4'h0);
    run_seq();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (obsq.size() == 0) begin
        n_fail++; $display("FAIL back_to_back missing: got no response, want one");
      end else begin
        o = obsq.pop_front();
        if ((o.resp !== e.err) || (o.waits != e.waits)) begin
          n_fail++;
          $display("FAIL back_to_back resp: got resp=%b waits=%0d, want resp=%b waits=%0d",
                   o.resp, o.waits, e.err, e.waits);
        end
        if (e.chk_data) begin
          n_cmp++;
          if (o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL back_to_back data: got %h, want %h", o.rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    obs_t o;
    sel = 1;
    add_txn(1'b1, 20'h00004, 3'd2, 32'hCAFEF00D, 4'hF);
    add_txn(1'b0, 20'h00004, 3'd2, 32'd0, 4'h0);
    add_txn(1'b1, 20'h00004, 3'd0, 32'h0000EE00, 4'h2);
    add_txn(1'b0, 20'h00004, 3'd2, 32'd0, 4'h0);
    add_txn(1'b0, 20'h01000, 3'd2, 32'd0, 4'h0);
    run_seq();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (obsq.size() == 0) begin
        n_fail++; $display("FAIL wait_states missing: got no response, want one");
      end else begin
        o = obsq.pop_front();
        if ((o.resp !== e.err) || (o.waits != e.waits) || (o.stall_resp !== e.err)) begin
          n_fail++;
          $display("FAIL wait_states resp: got resp=%b waits=%0d, want resp=%b waits=%0d",
                   o.resp, o.waits, e.err, e.waits);
        end
        if (e.chk_data) begin
          n_cmp++;
          if (o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL wait_states data: got %h, want %h", o.rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    obs_t o;
    sel = 0;
    add_txn(1'b1, 20'h00000, 3'd2, 32'h12345678, 4'hF);
    add_txn(1'b0, 20'h01000, 3'd2, 32'd0, 4'h0);
    add_txn(1'b1, 20'h01000, 3'd2, 32'hFFFFFFFF, 4'hF);
    add_txn(1'b0, 20'h00000, 3'd2, 32'd0, 4'h0);
    add_txn(1'b0, 20'h00003, 3'd1, 32'd0, 4'h0);
    add_txn(1'b0, 20'h00000, 3'd3, 32'd0, 4'h0);
    add_txn(1'b0, 20'h00002, 3'd1, 32'd0, 4'h0);
    add_txn(1'b0, 20'h00FFC, 3'd2, 32'd0, 4'h0);
    run_seq();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (obsq.size() == 0) begin
        n_fail++; $display("FAIL errors missing: got no response, want one");
      end else begin
        o = obsq.pop_front();
        if ((o.resp !== e.err) || (o.waits != e.waits) || (o.stall_resp !== e.err)) begin
          n_fail++;
          $display("FAIL errors resp: got resp=%b waits=%0d, want resp=%b waits=%0d",
                   o.resp, o.waits, e.err, e.waits);
        end
        if (e.chk_data && !(e.rdata === 32'hXXXXXXXX)) begin
          n_cmp++;
          if (o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL errors data: got %h, want %h", o.rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_reset_wait();
    exp_t e;
    obs_t o;
    sel = 2;
    add_txn(1'b1, 20'h00008, 3'd2, 32'h11112222, 4'hF);
    run_seq();
    void'(expq.pop_front());
    void'(obsq.pop_front());
    hsel_r = 1'b1; htrans_r = 2'd2; hwrite_r = 1'b1; haddr_r = 20'h00008; hsize_r = 3'd2;
    @(posedge hclk); #1;
    hsel_r = 1'b0; htrans_r = 2'd0; hwdata_r = 32'hFFFFFFFF; hwstrb_r = 4'hF;
    @(negedge hclk);
    n_cmp++;
    if (ro_m !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait stall: got ready=%b, want 0", ro_m);
    end
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    n_cmp++;
    if ((ro_m !== 1'b1) || (rs_m !== 1'b0) || (rd_m !== 32'd0)) begin
      n_fail++;
      $display("FAIL reset_wait outputs: got ready=%b resp=%b rdata=%h, want 1 0 00000000",
               ro_m, rs_m, rd_m);
    end
    @(posedge hclk); #1;
    add_txn(1'b0, 20'h00008, 3'd2, 32'd0, 4'h0);
    run_seq();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (obsq.size() == 0) begin
        n_fail++; $display("FAIL reset_wait missing: got no response, want one");
      end else begin
        o = obsq.pop_front();
        if ((o.resp !== e.err) || (o.waits != e.waits) || (o.rdata !== e.rdata)) begin
          n_fail++;
          $display("FAIL reset_wait read: got resp=%b waits=%0d data=%h, want resp=%b waits=%0d data=%h",
                   o.resp, o.waits, o.rdata, e.err, e.waits, e.rdata);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

AHB-Lite subordinate that terminates transfers issued by the Renode AHB manager stage and backs them with a synchronous word-organised SRAM. It decodes address phases, inserts a configurable number of wait states, applies byte strobes on writes, returns registered read data, and signals the two-cycle ERROR response for out-of-range, misaligned or oversized transfers. It sits directly downstream of the manager on the same `renode_ahb_if` signal set and is used as the default memory target in co-simulation testbenches.

## Interface
- `AddressWidth`, 20: width of `haddr`; byte address.
- `DataWidth`, 32: width of `hwdata`/`hrdata`; one of 8, 16, 32, 64.
- `MemoryDepth`, 1024: number of `DataWidth`-bit words; legal byte range is 0 to MemoryDepth*DataWidth/8-1.
- `WaitStates`, 0: number of low-`hreadyout` cycles inserted before completing each OKAY data phase; 0 to 15.

Ports:
- `hclk` input 1: single clock; all state is updated on the rising edge.
- `hreset` input 1: synchronous, active-high reset.
- `hsel` input 1: subordinate select.
- `haddr` input AddressWidth: transfer address.
- `htrans` input 2: Idle=0, Busy=1, NonSequential=2, Sequential=3.
- `hwrite` input 1: 1 = write.
- `hsize` input 3: transfer size, bytes = 1<<hsize.
- `hburst` input 3: ignored.
- `hwdata` input DataWidth: write data, valid in the data phase.
- `hwstrb` input DataWidth/8: byte-lane write enables, valid in the data phase.
- `hready` input 1: bus-level ready; an address phase is accepted only when it is 1.
- `hreadyout` output 1: 0 stalls the current data phase.
- `hresp` output 1: 0 = Okay, 1 = Error.
- `hrdata` output DataWidth: read data, valid when `hreadyout`=1 in a read data phase.

## Operation
- An address phase is accepted on the edge where `hsel && htrans[1] && hready`. The block then latches `haddr`, `hwrite` and `hsize`.
- A transfer is legal only when all three of the following hold:
  - `(8<<hsize) <= DataWidth`;
  - `haddr` is aligned to `1<<hsize`;
  - the word index `haddr / (DataWidth/8)` is less than `MemoryDepth`.
- Idle and Busy transfers, and cycles with `hsel`=0, get a zero-wait OKAY: `hreadyout`=1 and `hresp`=0.
- The FSM has four states:
  - IDLE: `hreadyout`=1, `hresp`=0. A legal accept with WaitStates>0 goes to WAIT with the counter set to WaitStates-1. A legal accept with WaitStates=0 stays in IDLE; the next cycle is the completing data phase. An illegal accept goes to ERR1.
  - WAIT: `hreadyout`=0, `hresp`=0. The counter decrements each cycle. At 0 the FSM goes to IDLE, and that next cycle completes the data phase with `hreadyout`=1.
  - ERR1: `hreadyout`=0, `hresp`=1. Always goes to ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1. Behaves as IDLE for accepting a new address phase.
- Write commit:
  - Happens on the edge ending the completing data phase (the cycle where `hreadyout`=1).
  - Byte lane i of the addressed word takes `hwdata[8i+7:8i]` when `hwstrb[i]`=1.
  - Errored transfers never write.
- Read data:
  - `hrdata` is registered from the array so that it is valid in the completing data phase.
  - When a read's completing cycle coincides with, or immediately follows, the commit of a write to the same word, `hrdata` must reflect the new bytes, merged per `hwstrb`, so that there is no stale data.
  - `hrdata` holds its value outside read completions.
  - `hrdata` is 0 in an error response.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter 0, no pending transfer.
- Latency from an accepted address phase to the completing data phase is 1+WaitStates cycles.
- Error response is exactly 2 cycles (ERR1 then ERR2), independent of WaitStates.
- Back-to-back transfers:
  - A new address phase may be accepted in the completing cycle of the previous transfer (pipelined).
  - No address phase is accepted while `hreadyout`=0, because `hready` from the bus is then 0.
- Reset asserted mid-transfer (WAIT, ERR1 or ERR2) has two required effects:
  - It returns the FSM to IDLE on the next edge.
  - It discards any pending write, so no array update occurs.
- `htrans` may be driven Idle during ERR1. The block still completes ERR2.

## Test plan
- Write then read, WaitStates=0: write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10 → write completes 1 cycle after its address phase; read returns 0xDEADBEEF with `hresp`=0.
- Byte strobe, back-to-back: write 0xAABBCCDD with strobe 0xF, then write 0x00000011 with strobe 0x1 to 0x20, then immediately read 0x20 → read returns 0xAABBCC11 (forwarding path).
- Wait states, WaitStates=3: read 0x4 → `hreadyout` is low for exactly 3 cycles, then high with the data; total latency is 4 cycles.
- Out-of-range address: MemoryDepth=1024, read 0x1000 → ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (`hreadyout`=1, `hresp`=1); `hrdata`=0. A write to the same address leaves memory unchanged.
- Size and alignment errors: a halfword access to 0x3 errors; a 64-bit access with DataWidth=32 errors; a halfword access to 0x2 returns OKAY.
- Reset during WAIT, WaitStates=5: issue a write, then assert `hreset` on the 2nd wait cycle → outputs return to reset values next cycle; a subsequent read shows the old contents.
